// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for pipeline stage registers: state encoding and
// the default payload width/reset value used by the core's stage instances.
package pipe_pkg;

  localparam int PIPE_WIDTH = 32;
  localparam logic [PIPE_WIDTH-1:0] PIPE_RESET_VAL = '0;

  // The encoding is the number of entries held.
  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_FULL      = 2'd1,
    ST_SKID_FULL = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream and downstream handshake of one pipeline stage register, plus its
// occupancy state for observation.
//
// Handshake: a transfer happens at a rising clk edge where valid & ready.
// The producer holds valid and data stable until that edge. ready may depend
// on the current state but never on valid. The stage never drops valid once
// raised, except through flush or reset.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  pipe_state_e      state;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, state
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, state
  );
endinterface

// File: rtl/pipe_stage_reg_en_reg.sv
// WIDTH-bit register with load enable and asynchronous active-high reset to
// RESET_VAL: the multi-bit form of the core's original stage flip-flop.
module en_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and synchronous flush.
// SKID=1 registers in_ready behind a 2-entry skid; SKID=0 is one entry with ready pass-through.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = PIPE_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               SKID      = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  pipe_stage_reg_if.slave bus
);

  logic             accept;
  logic             send;
  logic             main_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;

  assign accept       = bus.in_valid & bus.in_ready;
  assign send         = bus.out_valid & bus.out_ready;
  assign bus.out_data = main_q;

  en_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .d   (main_d),
    .q   (main_q)
  );

  generate
    if (SKID) begin : g_skid
      pipe_state_e      state_q;
      logic             ready_q;
      logic             valid_q;
      logic             skid_en;
      logic [WIDTH-1:0] skid_q;

      en_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (skid_en),
        .d   (bus.in_data),
        .q   (skid_q)
      );

      // Flush wins over accept; a send on the same edge needs no action here.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_q <= ST_EMPTY;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end else if (flush) begin
          state_q <= ST_EMPTY;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end else begin
          unique case (state_q)
            ST_EMPTY: begin
              if (accept) begin
                state_q <= ST_FULL;
                valid_q <= 1'b1;
              end
            end
            ST_FULL: begin
              if (accept && !send) begin
                state_q <= ST_SKID_FULL;
                ready_q <= 1'b0;
              end else if (!accept && send) begin
                state_q <= ST_EMPTY;
                valid_q <= 1'b0;
              end
            end
            ST_SKID_FULL: begin
              if (send) begin
                state_q <= ST_FULL;
                ready_q <= 1'b1;
              end
            end
            default: begin
              state_q <= ST_EMPTY;
              ready_q <= 1'b1;
              valid_q <= 1'b0;
            end
          endcase
        end
      end

      // Data registers load only on accept or on the skid-to-main move.
      always_comb begin
        main_en = 1'b0;
        skid_en = 1'b0;
        main_d  = bus.in_data;
        if (!flush) begin
          unique case (state_q)
            ST_EMPTY: main_en = accept;
            ST_FULL: begin
              main_en = accept & send;
              skid_en = accept & ~send;
            end
            ST_SKID_FULL: begin
              main_en = send;
              main_d  = skid_q;
            end
            default: ;
          endcase
        end
      end

      assign bus.in_ready  = ready_q;
      assign bus.out_valid = valid_q;
      assign bus.state     = state_q;
    end else begin : g_single
      logic valid_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q <= 1'b0;
        end else if (flush) begin
          valid_q <= 1'b0;
        end else if (accept) begin
          valid_q <= 1'b1;
        end else if (send) begin
          valid_q <= 1'b0;
        end
      end

      assign main_en       = accept & ~flush;
      assign main_d        = bus.in_data;
      assign bus.in_ready  = ~valid_q | bus.out_ready;
      assign bus.out_valid = valid_q;
      assign bus.state     = valid_q ? ST_FULL : ST_EMPTY;
    end
  endgenerate

endmodule
